// File: rtl/synth_pkg.sv
// Shared types and power-on defaults for the polyphonic synthesizer.
package synth_pkg;

    typedef enum logic [2:0] {
        ENV_IDLE    = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_DECAY   = 3'd2,
        ENV_SUSTAIN = 3'd3,
        ENV_RELEASE = 3'd4
    } env_state_e;

    localparam logic [7:0]  DEF_ADSR_AI  = 8'd64;
    localparam logic [7:0]  DEF_ADSR_DI  = 8'd16;
    localparam logic [7:0]  DEF_ADSR_S   = 8'd128;
    localparam logic [7:0]  DEF_ADSR_RI  = 8'd2;
    localparam logic [7:0]  DEF_PERIOD   = 8'd66;
    localparam logic [15:0] DEF_FILTER_A = 16'd17546;
    localparam logic [15:0] DEF_FILTER_B = 16'hFFFF - 16'd17546;

endpackage

// File: rtl/synth_voice.sv
// One voice: square oscillator gated by an ADSR envelope.
module synth_voice
    import synth_pkg::*;
#(
    parameter int ENV_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_i,
    input  logic             trig_i,
    input  logic [CNT_W-1:0] osc_count_i,
    input  logic [ENV_W-1:0] ai_i,
    input  logic [ENV_W-1:0] di_i,
    input  logic [ENV_W-1:0] s_i,
    input  logic [ENV_W-1:0] ri_i,
    output logic [ENV_W-1:0] sample_o,
    output logic             busy_o
);

    localparam logic [ENV_W:0] ENV_MAX = {1'b0, {ENV_W{1'b1}}};

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sq_q, sq_d;
    logic [ENV_W-1:0] env_q, env_d;
    env_state_e       st_q, st_d;

    logic [ENV_W:0]   att_sum;
    logic             att_top;
    logic [ENV_W-1:0] att_env;
    logic             rel_zero;
    logic [ENV_W-1:0] rel_env;
    logic             dec_floor;

    // Wrap with >= so a shrinking period never lets the counter run away.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        sq_d  = sq_q;
        if (osc_count_i == '0) begin
            cnt_d = '0;
            sq_d  = 1'b0;
        end else if (cnt_q >= osc_count_i - 1'b1) begin
            cnt_d = '0;
            sq_d  = ~sq_q;
        end
    end

    assign att_sum   = {1'b0, env_q} + {1'b0, ai_i};
    assign att_top   = att_sum >= ENV_MAX;
    assign att_env   = att_top ? {ENV_W{1'b1}} : att_sum[ENV_W-1:0];
    assign rel_zero  = ri_i >= env_q;
    assign rel_env   = rel_zero ? '0 : env_q - ri_i;
    assign dec_floor = (di_i > env_q) || ((env_q - di_i) <= s_i);

    always_comb begin
        st_d  = st_q;
        env_d = env_q;
        if (tick_i) begin
            unique case (st_q)
                ENV_IDLE: begin
                    if (trig_i) begin
                        env_d = att_env;
                        st_d  = att_top ? ENV_DECAY : ENV_ATTACK;
                    end
                end
                ENV_ATTACK, ENV_DECAY, ENV_SUSTAIN: begin
                    if (!trig_i) begin
                        env_d = rel_env;
                        st_d  = rel_zero ? ENV_IDLE : ENV_RELEASE;
                    end else if (st_q == ENV_ATTACK) begin
                        env_d = att_env;
                        st_d  = att_top ? ENV_DECAY : ENV_ATTACK;
                    end else if (st_q == ENV_DECAY) begin
                        env_d = dec_floor ? s_i : env_q - di_i;
                        st_d  = dec_floor ? ENV_SUSTAIN : ENV_DECAY;
                    end else begin
                        env_d = s_i;
                    end
                end
                ENV_RELEASE: begin
                    if (trig_i) begin
                        env_d = att_env;
                        st_d  = att_top ? ENV_DECAY : ENV_ATTACK;
                    end else begin
                        env_d = rel_env;
                        st_d  = rel_zero ? ENV_IDLE : ENV_RELEASE;
                    end
                end
                default: st_d = ENV_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            sq_q  <= 1'b0;
            env_q <= '0;
            st_q  <= ENV_IDLE;
        end else begin
            cnt_q <= cnt_d;
            sq_q  <= sq_d;
            env_q <= env_d;
            st_q  <= st_d;
        end
    end

    assign sample_o = sq_q ? env_q : '0;
    assign busy_o   = st_q != ENV_IDLE;

endmodule

// File: rtl/poly_synth.sv
// Polyphonic square synth: voices, mixer, one-pole filter, 1st-order sigma-delta.
module poly_synth
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int ENV_W      = 8,
    parameter int CNT_W      = 8,
    parameter int COEF_W     = 16,
    parameter int TICK_DIV   = 50
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_VOICES-1:0]       trig,
    input  logic [NUM_VOICES*CNT_W-1:0] osc_count,
    input  logic [ENV_W-1:0]            adsr_ai,
    input  logic [ENV_W-1:0]            adsr_di,
    input  logic [ENV_W-1:0]            adsr_s,
    input  logic [ENV_W-1:0]            adsr_ri,
    input  logic [COEF_W-1:0]           filter_a,
    input  logic [COEF_W-1:0]           filter_b,
    output logic                        data,
    output logic [NUM_VOICES-1:0]       voice_busy
);

    localparam int MIX_W  = ENV_W + $clog2(NUM_VOICES);
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick;
    logic [ENV_W-1:0]  sample [NUM_VOICES];
    logic [MIX_W-1:0]  mix_q, mix_d;
    logic [COEF_W-1:0] x;
    logic [COEF_W-1:0] y_q, y_d;
    logic [COEF_W:0]   acc_q, acc_d;
    logic [2*COEF_W-1:0] prod_a, prod_b;
    logic [2*COEF_W:0]   filt_sum;

    assign tick       = tick_cnt_q == TICK_LAST;
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        synth_voice #(
            .ENV_W (ENV_W),
            .CNT_W (CNT_W)
        ) u_voice (
            .clk         (clk),
            .rst         (rst),
            .tick_i      (tick),
            .trig_i      (trig[v]),
            .osc_count_i (osc_count[v*CNT_W +: CNT_W]),
            .ai_i        (adsr_ai),
            .di_i        (adsr_di),
            .s_i         (adsr_s),
            .ri_i        (adsr_ri),
            .sample_o    (sample[v]),
            .busy_o      (voice_busy[v])
        );
    end

    always_comb begin
        mix_d = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            mix_d = mix_d + MIX_W'(sample[v]);
        end
    end

    // Mix sits in the top bits so full scale maps to full-scale COEF_W.
    assign x        = COEF_W'(mix_q) << (COEF_W - MIX_W);
    assign prod_a   = {{COEF_W{1'b0}}, filter_a} * {{COEF_W{1'b0}}, x};
    assign prod_b   = {{COEF_W{1'b0}}, filter_b} * {{COEF_W{1'b0}}, y_q};
    assign filt_sum = {1'b0, prod_a} + {1'b0, prod_b};
    assign y_d      = COEF_W'(filt_sum >> COEF_W);
    assign acc_d    = {1'b0, acc_q[COEF_W-1:0]} + {1'b0, y_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt_q <= '0;
            mix_q      <= '0;
            y_q        <= '0;
            acc_q      <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            mix_q      <= mix_d;
            y_q        <= y_d;
            acc_q      <= acc_d;
        end
    end

    assign data = acc_q[COEF_W];

endmodule

// File: doc/poly_synth.md
POLY_SYNTH -- requirements
Module: poly_synth

Interface
REQ-001 Parameter NUM_VOICES, default 4: number of independent voices (1..8).
REQ-002 Parameter ENV_W, default 8: envelope amplitude width.
REQ-003 Parameter CNT_W, default 8: oscillator half-period counter width.
REQ-004 Parameter COEF_W, default 16: filter coefficient and sample width; COEF_W >= ENV_W + clog2(NUM_VOICES).
REQ-005 Parameter TICK_DIV, default 50: clocks per envelope step.
REQ-006 clk  in  1  single system clock; all logic on rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 trig  in  NUM_VOICES  per-voice gate, level-sensitive.
REQ-009 osc_count  in  NUM_VOICES*CNT_W  per-voice square half-period in clocks; voice v in slice [v*CNT_W +: CNT_W].
REQ-010 adsr_ai, adsr_di, adsr_s, adsr_ri  in  ENV_W each  shared attack/decay/release step per tick and sustain level.
REQ-011 filter_a, filter_b  in  COEF_W each  one-pole coefficients, scaled by 2^-COEF_W.
REQ-012 data  out  1  sigma-delta audio bitstream.
REQ-013 voice_busy  out  NUM_VOICES  high while voice envelope state is not IDLE.

Function
REQ-014 Tick counter SHALL count 0..TICK_DIV-1 and assert a one-cycle tick on wrap; first tick TICK_DIV clocks after reset release.
REQ-015 Per voice, oscillator counter SHALL count 0..osc_count-1 and toggle square on wrap; period 2*osc_count clocks; osc_count=0 holds counter 0 and square 0.
REQ-016 Per voice, envelope FSM states IDLE, ATTACK, DECAY, SUSTAIN, RELEASE; env value changes only on tick; state transitions below are evaluated on tick.
REQ-017 IDLE or RELEASE with trig=1 -> ATTACK (retrigger keeps current env, no reset to 0).
REQ-018 ATTACK: env = min(env+ai, 2^ENV_W-1); on reaching max -> DECAY; ai=0 holds in ATTACK.
REQ-019 DECAY: if env-di <= s or underflows then env=s, -> SUSTAIN; else env -= di.
REQ-020 SUSTAIN: env tracks live adsr_s each tick.
REQ-021 ATTACK/DECAY/SUSTAIN with trig=0 -> RELEASE (same tick, release takes priority over step).
REQ-022 RELEASE: env = max(env-ri, 0); reaching 0 -> IDLE; ri=0 holds in RELEASE until retrigger.
REQ-023 Voice sample = square ? env : 0; mix = unsigned sum of all voice samples, registered, no overflow (width ENV_W+clog2(NUM_VOICES)).
REQ-024 Filter input x = mix left-aligned to COEF_W bits; y <= (filter_a*x + filter_b*y) >> COEF_W each clock, full-width product, truncated result.
REQ-025 Sigma-delta: acc (COEF_W+1 bits) <= acc[COEF_W-1:0] + y; data = registered carry acc[COEF_W].
REQ-026 Latency voice sample -> data: 3 clocks (mix, filter, modulator registers).
REQ-027 Simultaneous trig change on several voices SHALL be handled independently in the same tick.

Reset
REQ-028 rst=0 SHALL immediately clear: data=0, voice_busy=0, all envelopes 0 in IDLE, oscillator/tick counters 0, squares 0, mix, y, acc 0.
REQ-029 Reset mid-operation (any state) SHALL produce the same state as power-up reset; trig held high at release of reset enters ATTACK on first tick.

Structure
REQ-030 Package synth_pkg SHALL hold the envelope state enum and default constants (ADSR 64/16/128/2, period 66, filter_a 17546, filter_b 0xFFFF-17546).
REQ-031 Sub-module synth_voice (oscillator + envelope FSM) SHALL be instantiated NUM_VOICES times; tick, mixer, filter, modulator stay in poly_synth.

Verification (NUM_VOICES=2, TICK_DIV=4)
REQ-032 trig0=1, ai=64, di=16, s=128 -> env0 64,128,192,255 on ticks 1-4, then 239..143, 128 on tick 12, SUSTAIN.
REQ-033 From SUSTAIN 128, trig0=0, ri=2 -> env0 decreases by 2 per tick, 0 after 64 ticks, voice_busy[0] falls same tick.
REQ-034 osc_count0=3 -> square0 toggles every 3 clocks; osc_count1=0 -> voice1 sample stays 0 despite trig1=1.
REQ-035 filter_a=0x8000, filter_b=0x8000, constant y forced to 0x4000 -> exactly 16 ones in any 64 consecutive data bits.
REQ-036 rst=0 asynchronously while env0=128 in DECAY -> env0=0, IDLE, data=0, voice_busy=0 before next clock edge.
REQ-037 Retrigger in RELEASE at env0=100 -> ATTACK resumes from 100 (164 next tick).
